io_bus_fabric: RTL and testbench
================================

Name: io_bus_fabric

Overview:
Parametrised I/O-space decoder and response fabric for the CPU data bus (d_io cycles). It generalises the fixed casez decode and wired-OR ack/data of the system top into N address-windowed slave channels. It adds a registered response mux, floating-bus data for unmapped ports, and a per-access ack timeout so a hung peripheral cannot stall the core. It sits between Core's data master port (qualified by d_io) and the I/O register blocks (UART, SPI, PIC, timer, VGA regs, PS/2, ...).

Parameters:
NUM_PORTS, 8, number of slave channels (1..16)
ADDR_W, 16, I/O byte-address width; bus carries bits [ADDR_W-1:1]
PORT_BASE, all zero, packed NUM_PORTS*ADDR_W vector; channel i base address, bit 0 ignored
PORT_MASK, all ones, packed NUM_PORTS*ADDR_W vector; channel i compare mask, 1 = bit compared
TIMEOUT, 255, cycles to wait for a slave ack before the fabric self-acks (1..65535)
FLOAT_DATA, 16'hffff, read data returned for unmapped or timed-out accesses

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_access  in  1  master access request, held until m_ack
m_addr  in  ADDR_W-1  master word address [ADDR_W-1:1]
m_ack  out  1  registered single-cycle completion to master
m_data_out  out  16  registered read data to master, valid with m_ack
s_cs  out  NUM_PORTS  one-hot slave select
s_ack  in  NUM_PORTS  per-slave ack
s_data  in  NUM_PORTS*16  per-slave read data, slice i = channel i
timeout_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset values: m_ack=0, m_data_out=0, s_cs=0, timeout_sticky=0, FSM=IDLE, timeout counter=0.
- Decode: channel i hits when ({m_addr,1'b0} ^ base_i) & mask_i == 0. If several hit, the lowest index wins. Decode is registered on entry to SLAVE.
- IDLE: on m_access with a hit, latch index, go to SLAVE. On m_access with no hit, go to UNMAPPED.
- SLAVE: s_cs[idx]=1, all other s_cs bits 0. Counter increments each cycle.
  - s_ack[idx]=1: capture s_data slice idx into m_data_out, pulse m_ack next cycle, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: m_data_out=FLOAT_DATA, pulse m_ack, set timeout_sticky, go to DONE.
  - Acks on non-selected channels are ignored.
- UNMAPPED: one cycle. m_data_out=FLOAT_DATA, pulse m_ack, go to DONE. Unmapped latency is 2 cycles from m_access.
- DONE: s_cs=0, m_ack=1 for exactly this cycle, counter cleared, return to IDLE. A back-to-back m_access is sampled in IDLE on the next cycle, so there is at least one idle cycle between accesses.
- Latency, mapped: s_cs asserts 1 cycle after m_access. m_ack follows 1 cycle after s_ack.
- Ack and timeout on the same cycle: the slave ack wins. Data is the slave's and timeout_sticky is not set.
- m_access dropped while in SLAVE: abort to IDLE, s_cs=0, no m_ack, counter cleared.
- Reset mid-access: immediate return to reset values. No ack is emitted.
- m_data_out holds its last value outside ack cycles. The master qualifies it with m_ack only.

Optional Feature:
IO_FABRIC_ERRLOG_EN
- Defined: adds ports err_clear (in, 1), err_valid (out, 1), err_addr (out, ADDR_W-1) and err_timeout (out, 1).
  - On an unmapped or timed-out access, if err_valid=0: latch m_addr and set err_timeout=1 for a timeout, 0 for unmapped; set err_valid.
  - Later errors do not overwrite the log until err_clear, which zeroes all three outputs next cycle.
  - err_clear on the same cycle as a new error: the clear wins.
  - All three outputs reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- NUM_PORTS=2, base0=16'hfffa mask all ones; m_access addr 16'hfffa; slave acks 2 cycles after cs with 16'h1234 -> s_cs=2'b01 at cycle 1; m_ack at cycle 4 with m_data_out=16'h1234.
- Access to 16'h0300 (no hit) -> s_cs stays 0; m_ack at cycle 2 with 16'hffff; timeout_sticky=0.
- TIMEOUT=8, selected slave never acks -> s_cs high for 8 cycles, then m_ack with 16'hffff; timeout_sticky=1 and stays 1 until reset.
- Overlapping windows: ch0 base 16'h0040 mask 16'hfffc, ch1 base 16'h0040 mask 16'hffff; access 16'h0040 -> only s_cs[0].
- m_access dropped 2 cycles into SLAVE; then reset asserted mid-access on a second access -> both return to IDLE with s_cs=0 and no m_ack.
- ERRLOG_EN: unmapped access 16'h0300, then timeout at 16'hfffa -> err_addr holds 16'h0300>>1 with err_timeout=0; err_clear -> all zero; a following timeout logs 16'hfffa with err_timeout=1.

Source files
------------

// File: rtl/io_bus_fabric.sv
// rtl/io_bus_fabric.sv - address-windowed I/O slave fabric with ack timeout and floating-bus reads
// Optional error log of the first unmapped/timed-out access: define IO_FABRIC_ERRLOG_EN.
module io_bus_fabric #(
    parameter int                          NUM_PORTS  = 8,
    parameter int                          ADDR_W     = 16,
    parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE  = '0,
    parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_MASK  = '1,
    parameter int                          TIMEOUT    = 255,
    parameter logic [15:0]                 FLOAT_DATA = 16'hffff
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_access,
    input  logic [ADDR_W-2:0]       m_addr,
    output logic                    m_ack,
    output logic [15:0]             m_data_out,
    output logic [NUM_PORTS-1:0]    s_cs,
    input  logic [NUM_PORTS-1:0]    s_ack,
    input  logic [NUM_PORTS*16-1:0] s_data,
    output logic                    timeout_sticky
`ifdef IO_FABRIC_ERRLOG_EN
    ,
    input  logic                    err_clear,
    output logic                    err_valid,
    output logic [ADDR_W-2:0]       err_addr,
    output logic                    err_timeout
`endif
);

    localparam int          IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SLAVE, UNMAPPED, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic [15:0]        data_q, data_d;
    logic               sticky_q, sticky_d;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [ADDR_W-1:0]  full_addr;
    logic               sel_ack;
    logic [15:0]        sel_data;

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        full_addr = {m_addr, 1'b0};
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (((full_addr ^ PORT_BASE[i*ADDR_W +: ADDR_W]) & PORT_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        s_cs     = '0;
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                s_cs[i]  = (state_q == SLAVE);
                sel_ack  = s_ack[i];
                sel_data = s_data[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        data_d   = data_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_access) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        state_d = SLAVE;
                    end else begin
                        state_d = UNMAPPED;
                    end
                end
            end
            SLAVE: begin
                cnt_d = cnt_q + 16'd1;
                if (!m_access) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    data_d  = sel_data;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    data_d   = FLOAT_DATA;
                    ack_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = DONE;
                end
            end
            UNMAPPED: begin
                data_d  = FLOAT_DATA;
                ack_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
        end
    end

    assign m_ack          = ack_q;
    assign m_data_out     = data_q;
    assign timeout_sticky = sticky_q;

`ifdef IO_FABRIC_ERRLOG_EN
    logic              err_valid_q;
    logic [ADDR_W-2:0] err_addr_q;
    logic              err_timeout_q;
    logic              to_event;
    logic              um_event;

    assign to_event = (state_q == SLAVE) && m_access && !sel_ack && (cnt_q == TO_LAST);
    assign um_event = (state_q == UNMAPPED);

    // Only the first error is kept until software clears it.
    always_ff @(posedge clk) begin
        if (reset || err_clear) begin
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else if ((to_event || um_event) && !err_valid_q) begin
            err_valid_q   <= 1'b1;
            err_addr_q    <= m_addr;
            err_timeout_q <= to_event;
        end
    end

    assign err_valid   = err_valid_q;
    assign err_addr    = err_addr_q;
    assign err_timeout = err_timeout_q;
`endif

endmodule

// File: tb/tb_io_bus_fabric.sv
// tb/tb_io_bus_fabric.sv - scoreboard bench for io_bus_fabric (3 channels, TIMEOUT=8)
module tb_io_bus_fabric;
    localparam int NP = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             m_access;
    logic [14:0]      m_addr;
    logic             m_ack;
    logic [15:0]      m_data_out;
    logic [NP-1:0]    s_cs;
    logic [NP-1:0]    s_ack;
    logic [NP*16-1:0] s_data;
    logic             timeout_sticky;
`ifdef IO_FABRIC_ERRLOG_EN
    logic             err_clear;
    logic             err_valid;
    logic [14:0]      err_addr;
    logic             err_timeout;
`endif

    always #5 clk = ~clk;

    io_bus_fabric #(
        .NUM_PORTS (NP),
        .ADDR_W    (16),
        .PORT_BASE ({16'h0040, 16'h0040, 16'hfffa}),
        .PORT_MASK ({16'hffff, 16'hfffc, 16'hffff}),
        .TIMEOUT   (8),
        .FLOAT_DATA(16'hffff)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_access      (m_access),
        .m_addr        (m_addr),
        .m_ack         (m_ack),
        .m_data_out    (m_data_out),
        .s_cs          (s_cs),
        .s_ack         (s_ack),
        .s_data        (s_data),
        .timeout_sticky(timeout_sticky)
`ifdef IO_FABRIC_ERRLOG_EN
        ,
        .err_clear     (err_clear),
        .err_valid     (err_valid),
        .err_addr      (err_addr),
        .err_timeout   (err_timeout)
`endif
    );

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   cc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Every m_ack must match the oldest expected response.
    always @(negedge clk) begin
        if (m_ack === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got m_ack=1 data=%h required no ack", m_data_out);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_data", m_data_out, mon_e.data);
                chk("ack_latency", cyc - start_cyc, mon_e.lat);
            end
        end
    end

    task automatic access(input logic [15:0] ba, input int ack_after, input logic [15:0] rdata,
                          input logic [NP-1:0] noise, input logic [NP-1:0] exp_cs,
                          input logic [15:0] exp_data, input int exp_lat, output int cs_cycles);
        bit got;
        int n;
        sb.push_back('{data: exp_data, lat: exp_lat});
        @(negedge clk);
        m_addr    = ba[15:1];
        m_access  = 1'b1;
        s_data    = {rdata ^ 16'h2222, rdata ^ 16'h1111, rdata};
        start_cyc = cyc;
        cs_cycles = 0;
        got       = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            n = cyc - start_cyc;
            if (s_cs != '0) cs_cycles++;
            if (n == 1) chk("cs_select", s_cs, exp_cs);
            if (m_ack === 1'b1) got = 1'b1;
            s_ack = ((ack_after >= 0 && n == ack_after + 1) ? exp_cs : '0) | noise;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_wait: got no m_ack in 40 cycles required m_ack at %0d", exp_lat);
        end
        m_access = 1'b0;
        s_ack    = '0;
    endtask

    initial begin
        reset    = 1'b1;
        m_access = 1'b0;
        m_addr   = '0;
        s_ack    = '0;
        s_data   = '0;
`ifdef IO_FABRIC_ERRLOG_EN
        err_clear = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_data", m_data_out, 0);
        chk("rst_s_cs", s_cs, 0);
        chk("rst_sticky", timeout_sticky, 0);
        reset = 1'b0;

        access(16'hfffa, 2, 16'h1234, 3'b000, 3'b001, 16'h1234, 4, cc);
        access(16'h0300, -1, 16'h0000, 3'b000, 3'b000, 16'hffff, 2, cc);
        chk("unmapped_cs_cycles", cc, 0);
        chk("unmapped_sticky", timeout_sticky, 0);
        access(16'hfffa, 2, 16'h5a5a, 3'b110, 3'b001, 16'h5a5a, 4, cc);
        access(16'h0040, 0, 16'h0bad, 3'b000, 3'b010, 16'h1abc, 2, cc);
        access(16'h0042, 1, 16'h4321, 3'b000, 3'b010, 16'h5230, 3, cc);
        access(16'hfffa, 7, 16'hbeef, 3'b000, 3'b001, 16'hbeef, 9, cc);
        chk("ack_at_limit_cs_cycles", cc, 8);
        chk("ack_at_limit_sticky", timeout_sticky, 0);
        access(16'hfffa, -1, 16'h0000, 3'b000, 3'b001, 16'hffff, 9, cc);
        chk("timeout_cs_cycles", cc, 8);
        chk("timeout_sticky_set", timeout_sticky, 1);
        access(16'h0040, 1, 16'h7777, 3'b000, 3'b010, 16'h6666, 3, cc);
        chk("sticky_holds", timeout_sticky, 1);

        // Abort: master drops its request two cycles into the slave phase.
        @(negedge clk);
        m_addr    = 15'h7ffd;
        m_access  = 1'b1;
        start_cyc = cyc;
        repeat (2) @(negedge clk);
        chk("abort_cs_before", s_cs, 3'b001);
        m_access = 1'b0;
        @(negedge clk);
        chk("abort_cs_after", s_cs, 0);
        chk("abort_no_ack", m_ack, 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a second access.
        m_access  = 1'b1;
        start_cyc = cyc;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs", s_cs, 0);
        chk("midrst_ack", m_ack, 0);
        chk("midrst_data", m_data_out, 0);
        chk("midrst_sticky", timeout_sticky, 0);
        reset    = 1'b0;
        m_access = 1'b0;
        repeat (3) @(negedge clk);

`ifdef IO_FABRIC_ERRLOG_EN
        chk("errlog_clean", err_valid, 0);
`endif
        access(16'h0300, -1, 16'h0000, 3'b000, 3'b000, 16'hffff, 2, cc);
`ifdef IO_FABRIC_ERRLOG_EN
        chk("errlog_um_valid", err_valid, 1);
        chk("errlog_um_addr", err_addr, 15'h0180);
        chk("errlog_um_to", err_timeout, 0);
`endif
        access(16'hfffa, -1, 16'h0000, 3'b000, 3'b001, 16'hffff, 9, cc);
`ifdef IO_FABRIC_ERRLOG_EN
        chk("errlog_keep_addr", err_addr, 15'h0180);
        chk("errlog_keep_to", err_timeout, 0);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("errlog_clr_valid", err_valid, 0);
        chk("errlog_clr_addr", err_addr, 0);
        chk("errlog_clr_to", err_timeout, 0);
`endif
        access(16'hfffa, -1, 16'h0000, 3'b000, 3'b001, 16'hffff, 9, cc);
`ifdef IO_FABRIC_ERRLOG_EN
        chk("errlog_to_valid", err_valid, 1);
        chk("errlog_to_addr", err_addr, 15'h7ffd);
        chk("errlog_to_to", err_timeout, 1);
`endif
        chk("final_sticky", timeout_sticky, 1);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
